// File: rtl/reg_file_arbiter_pkg.sv
// reg_file_arbiter_pkg
//   Shared types and constants for the register-file arbiter.
//   - rfa_state_e : access sequencer states (IDLE -> EXEC -> RESP)
//   - NUM_REQ     : number of requesters sharing the register file
//   - rfa_req_t   : one request record (op type, selects, write data) at the
//                   default register-file geometry
package reg_file_arbiter_pkg;

    localparam int NUM_REQ    = 2;
    localparam int RFA_DATA_W = 32;
    localparam int RFA_SEL_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } rfa_state_e;

    typedef struct packed {
        logic                  we;
        logic [RFA_SEL_W-1:0]  addr_a;
        logic [RFA_SEL_W-1:0]  addr_b;
        logic [RFA_DATA_W-1:0] wdata;
    } rfa_req_t;

endpackage

// File: rtl/reg_file_arbiter_rr_arbiter2.sv
// rr_arbiter2
//   Combinational two-way round-robin grant.
//   Ports:
//     i_req_valid   [1:0]  request valid per requester
//     i_last_grant         requester granted most recently (flop owned by parent)
//     o_grant_id           requester chosen this cycle
//     o_grant_valid        at least one requester is asking
module rr_arbiter2 (
    input  logic [1:0] i_req_valid,
    input  logic       i_last_grant,
    output logic       o_grant_id,
    output logic       o_grant_valid
);

    always_comb begin
        o_grant_valid = |i_req_valid;
        o_grant_id    = 1'b0;
        case (i_req_valid)
            2'b01:   o_grant_id = 1'b0;
            2'b10:   o_grant_id = 1'b1;
            // On a tie the requester that was not served last time wins.
            2'b11:   o_grant_id = ~i_last_grant;
            default: o_grant_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/reg_file_arbiter.sv
// reg_file_arbiter
//   Serialises read/write accesses from two requesters onto one register file.
//   Each access takes IDLE (accept) -> EXEC (drive file controls) -> RESP.
//   Ports:
//     clk, rst                      clock, asynchronous active-high reset
//     req_valid/req_ready [1:0]     request handshake per requester
//     req_we, req_addr_a/b, req_wdata  request payload per requester
//     rsp_valid/rsp_ready           response handshake
//     rsp_id, rsp_we, rsp_a, rsp_b  response owner, op echo, read data
//     rf_ld, rf_oe_a, rf_oe_b       register file controls
//     rf_sel_a, rf_sel_b, rf_in     register file selects and write data
//     rf_a, rf_b                    register file read buses
module reg_file_arbiter
    import reg_file_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = RFA_DATA_W,
    parameter int SEL_WIDTH  = RFA_SEL_W
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ-1:0]                   req_we,
    input  logic [NUM_REQ-1:0][SEL_WIDTH-1:0]    req_addr_a,
    input  logic [NUM_REQ-1:0][SEL_WIDTH-1:0]    req_addr_b,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata,
    output logic                                 rsp_valid,
    input  logic                                 rsp_ready,
    output logic                                 rsp_id,
    output logic                                 rsp_we,
    output logic [DATA_WIDTH-1:0]                rsp_a,
    output logic [DATA_WIDTH-1:0]                rsp_b,
    output logic                                 rf_ld,
    output logic                                 rf_oe_a,
    output logic                                 rf_oe_b,
    output logic [SEL_WIDTH-1:0]                 rf_sel_a,
    output logic [SEL_WIDTH-1:0]                 rf_sel_b,
    output logic [DATA_WIDTH-1:0]                rf_in,
    input  logic [DATA_WIDTH-1:0]                rf_a,
    input  logic [DATA_WIDTH-1:0]                rf_b
);

    rfa_state_e            r_state;
    rfa_state_e            w_state_nxt;
    logic                  r_last_grant;
    logic                  r_we;
    logic                  r_id;
    logic [SEL_WIDTH-1:0]  r_addr_a;
    logic [SEL_WIDTH-1:0]  r_addr_b;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rsp_a;
    logic [DATA_WIDTH-1:0] r_rsp_b;

    logic                  w_grant_id;
    logic                  w_grant_valid;
    logic                  w_accept;

    rr_arbiter2 u_rr_arbiter2 (
        .i_req_valid   (req_valid),
        .i_last_grant  (r_last_grant),
        .o_grant_id    (w_grant_id),
        .o_grant_valid (w_grant_valid)
    );

    // Gating with rst keeps req_ready low for the whole reset pulse, not
    // just after the state register has been forced back to IDLE.
    assign w_accept = (r_state == IDLE) && w_grant_valid && !rst;

    always_comb begin
        req_ready             = '0;
        req_ready[w_grant_id] = w_accept;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_state_nxt = EXEC;
            EXEC:                   w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accepted request is held for EXEC and RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_id         <= 1'b0;
            r_addr_a     <= '0;
            r_addr_b     <= '0;
            r_wdata      <= '0;
        end else if (w_accept) begin
            r_last_grant <= w_grant_id;
            r_id         <= w_grant_id;
            r_we         <= req_we[w_grant_id];
            r_addr_a     <= req_addr_a[w_grant_id];
            r_addr_b     <= req_addr_b[w_grant_id];
            r_wdata      <= req_wdata[w_grant_id];
        end
    end

    // Read data is sampled on the edge that ends EXEC; writes leave the
    // previous read data in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_a <= '0;
            r_rsp_b <= '0;
        end else if (r_state == EXEC && !r_we) begin
            r_rsp_a <= rf_a;
            r_rsp_b <= rf_b;
        end
    end

    // File controls are decoded purely from state, so an asynchronous reset
    // during EXEC drops rf_ld immediately and suppresses the write.
    always_comb begin
        rf_ld    = 1'b0;
        rf_oe_a  = 1'b0;
        rf_oe_b  = 1'b0;
        rf_sel_a = '0;
        rf_sel_b = '0;
        rf_in    = '0;
        if (r_state == EXEC) begin
            if (r_we) begin
                rf_ld    = 1'b1;
                rf_sel_a = r_addr_a;
                rf_in    = r_wdata;
            end else begin
                rf_oe_a  = 1'b1;
                rf_oe_b  = 1'b1;
                rf_sel_a = r_addr_a;
                rf_sel_b = r_addr_b;
            end
        end
    end

    assign rsp_valid = (r_state == RESP);
    assign rsp_id    = r_id;
    assign rsp_we    = r_we;
    assign rsp_a     = r_rsp_a;
    assign rsp_b     = r_rsp_b;

endmodule

// File: tb/tb_reg_file_arbiter.sv
module tb_reg_file_arbiter;
    import reg_file_arbiter_pkg::*;

    localparam int DW = 32;
    localparam int SW = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0]            req_we;
    logic [1:0][SW-1:0]    req_addr_a;
    logic [1:0][SW-1:0]    req_addr_b;
    logic [1:0][DW-1:0]    req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_id;
    logic                  rsp_we;
    logic [DW-1:0]         rsp_a;
    logic [DW-1:0]         rsp_b;
    logic                  rf_ld;
    logic                  rf_oe_a;
    logic                  rf_oe_b;
    logic [SW-1:0]         rf_sel_a;
    logic [SW-1:0]         rf_sel_b;
    logic [DW-1:0]         rf_in;
    logic [DW-1:0]         rf_a;
    logic [DW-1:0]         rf_b;

    typedef struct packed {
        logic          id;
        logic          we;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } exp_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    exp_t          q[$];
    logic [DW-1:0] sh [256];
    logic [DW-1:0] last_a = '0;
    logic [DW-1:0] last_b = '0;

    reg_file_arbiter #(.DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr_a (req_addr_a),
        .req_addr_b (req_addr_b),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_we     (rsp_we),
        .rsp_a      (rsp_a),
        .rsp_b      (rsp_b),
        .rf_ld      (rf_ld),
        .rf_oe_a    (rf_oe_a),
        .rf_oe_b    (rf_oe_b),
        .rf_sel_a   (rf_sel_a),
        .rf_sel_b   (rf_sel_b),
        .rf_in      (rf_in),
        .rf_a       (rf_a),
        .rf_b       (rf_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural register file driven by the arbiter's controls.
    logic [DW-1:0] rf_mem [256];
    always @(posedge clk) if (rf_ld) rf_mem[rf_sel_a] <= rf_in;
    assign rf_a = rf_oe_a ? rf_mem[rf_sel_a] : '0;
    assign rf_b = rf_oe_b ? rf_mem[rf_sel_b] : '0;

    // hs marks the cycle after a handshake, i.e. the only cycle that may
    // drive register-file controls.
    logic hs;
    always @(posedge clk or posedge rst) begin
        if (rst) hs <= 1'b0;
        else     hs <= |(req_valid & req_ready);
    end

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (!hs && (rf_ld || rf_oe_a || rf_oe_b || rf_sel_a != '0 || rf_sel_b != '0 || rf_in != '0)) begin
                errors++;
                $display("FAIL rf_ctrl_outside_exec t=%0t got ld=%b oea=%b oeb=%b sa=%h sb=%h in=%h expected all zero",
                         $time, rf_ld, rf_oe_a, rf_oe_b, rf_sel_a, rf_sel_b, rf_in);
            end else if (hs && rf_ld && (rf_oe_a || rf_oe_b)) begin
                errors++;
                $display("FAIL rf_ld_with_oe t=%0t got ld=%b oea=%b oeb=%b expected ld and oe exclusive",
                         $time, rf_ld, rf_oe_a, rf_oe_b);
            end
        end
    end

    task automatic push_exp(input logic id, input rfa_req_t r);
        exp_t e;
        e.id = id;
        e.we = r.we;
        if (r.we) begin
            sh[r.addr_a] = r.wdata;
            e.a = last_a;
            e.b = last_b;
        end else begin
            e.a = sh[r.addr_a];
            e.b = sh[r.addr_b];
            last_a = e.a;
            last_b = e.b;
        end
        q.push_back(e);
    endtask

    task automatic drive_req(input logic p, input rfa_req_t r);
        req_we[p]     = r.we;
        req_addr_a[p] = r.addr_a;
        req_addr_b[p] = r.addr_b;
        req_wdata[p]  = r.wdata;
        req_valid[p]  = 1'b1;
        #1;
    endtask

    // One complete access; returns at the first negedge with rsp_valid high.
    task automatic xact(input logic p, input rfa_req_t r, output bit ok,
                        output int acc, output int lat, output exp_t obs, output exp_t ex);
        ok = 0; acc = 0; lat = 0; obs = '0; ex = '0;
        drive_req(p, r);
        for (int i = 0; i < 20 && !ok; i++) begin
            if (req_ready[p]) ok = 1;
            else @(negedge clk);
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout port=%0d got req_ready=%b expected handshake", p, req_ready);
            req_valid[p] = 1'b0;
            return;
        end
        acc = cyc;
        push_exp(p, r);
        @(posedge clk);
        @(negedge clk);
        req_valid[p] = 1'b0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (rsp_valid) ok = 1;
            else @(negedge clk);
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL rsp_timeout port=%0d got rsp_valid=0 expected 1", p);
            return;
        end
        lat = cyc - acc;
        obs = '{id: rsp_id, we: rsp_we, a: rsp_a, b: rsp_b};
        ex  = (q.size() > 0) ? q.pop_front() : '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_a = '0;
        last_b = '0;
        q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_id !== 1'b0 || rsp_we !== 1'b0) begin errors++; $display("FAIL reset_rsp_id_we got=%b%b exp=00", rsp_id, rsp_we); end
        checks++; if (rsp_a !== '0 || rsp_b !== '0) begin errors++; $display("FAIL reset_rsp_data got=%h/%h exp=0/0", rsp_a, rsp_b); end
        checks++;
        if ({rf_ld, rf_oe_a, rf_oe_b} !== 3'b000 || rf_sel_a !== '0 || rf_sel_b !== '0 || rf_in !== '0) begin
            errors++; $display("FAIL reset_rf_ctrl got ld=%b oea=%b oeb=%b sa=%h sb=%h in=%h exp all 0",
                               rf_ld, rf_oe_a, rf_oe_b, rf_sel_a, rf_sel_b, rf_in);
        end
        @(negedge clk);
        req_valid = 2'b00;
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        bit ok; int acc; int lat; exp_t o; exp_t e;
        xact(1'b0, '{we: 1'b1, addr_a: 8'd2, addr_b: 8'd0, wdata: 32'd123}, ok, acc, lat, o, e);
        checks++; if (!ok || o !== e) begin errors++; $display("FAIL wr0_rsp got=%h exp=%h", o, e); end
        checks++; if (lat != 2) begin errors++; $display("FAIL wr0_latency got=%0d exp=2", lat); end
        xact(1'b0, '{we: 1'b0, addr_a: 8'd2, addr_b: 8'd2, wdata: 32'd0}, ok, acc, lat, o, e);
        checks++; if (!ok || o !== e) begin errors++; $display("FAIL rd0_rsp got=%h exp=%h", o, e); end
        checks++; if (o.a !== 32'd123 || o.b !== 32'd123 || o.id !== 1'b0) begin
            errors++; $display("FAIL rd0_value got id=%b a=%0d b=%0d exp id=0 a=123 b=123", o.id, o.a, o.b);
        end
        checks++; if (lat != 2) begin errors++; $display("FAIL rd0_latency got=%0d exp=2", lat); end
    endtask

    task automatic test_back_to_back();
        bit ok; int acc; int prev; int lat; exp_t o; exp_t e;
        xact(1'b1, '{we: 1'b1, addr_a: 8'd3, addr_b: 8'd0, wdata: 32'd321}, ok, prev, lat, o, e);
        checks++; if (!ok || o !== e) begin errors++; $display("FAIL wr1_rsp got=%h exp=%h", o, e); end
        xact(1'b0, '{we: 1'b1, addr_a: 8'd2, addr_b: 8'd0, wdata: 32'd567}, ok, acc, lat, o, e);
        checks++; if (!ok || o !== e) begin errors++; $display("FAIL wr0b_rsp got=%h exp=%h", o, e); end
        checks++; if (acc - prev != 3) begin errors++; $display("FAIL b2b_interval got=%0d exp=3", acc - prev); end
        prev = acc;
        xact(1'b0, '{we: 1'b0, addr_a: 8'd2, addr_b: 8'd3, wdata: 32'd0}, ok, acc, lat, o, e);
        checks++; if (!ok || o !== e) begin errors++; $display("FAIL rd23_rsp got=%h exp=%h", o, e); end
        checks++; if (o.a !== 32'd567 || o.b !== 32'd321) begin
            errors++; $display("FAIL rd23_value got a=%0d b=%0d exp a=567 b=321", o.a, o.b);
        end
        checks++; if (acc - prev != 3) begin errors++; $display("FAIL b2b_interval2 got=%0d exp=3", acc - prev); end
        @(negedge clk);
    endtask

    task automatic test_arbitration();
        rfa_req_t rq [2];
        int   n_acc = 0;
        int   n_rsp = 0;
        int   last_acc = 0;
        logic gexp = 1'b0;
        bit   acc_now;
        exp_t o;
        exp_t e;
        apply_reset();
        rq[0] = '{we: 1'b0, addr_a: 8'd2, addr_b: 8'd2, wdata: 32'd0};
        rq[1] = '{we: 1'b0, addr_a: 8'd2, addr_b: 8'd3, wdata: 32'd0};
        req_we[0] = rq[0].we; req_addr_a[0] = rq[0].addr_a; req_addr_b[0] = rq[0].addr_b; req_wdata[0] = rq[0].wdata;
        req_we[1] = rq[1].we; req_addr_a[1] = rq[1].addr_a; req_addr_b[1] = rq[1].addr_b; req_wdata[1] = rq[1].wdata;
        req_valid = 2'b11;
        #1;
        for (int i = 0; i < 60 && n_rsp < 4; i++) begin
            acc_now = 0;
            if (req_ready != 2'b00) begin
                checks++;
                if (req_ready !== (gexp ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL arb_grant n=%0d got=%b exp=%b", n_acc, req_ready, gexp ? 2'b10 : 2'b01);
                end
                if (n_acc > 0) begin
                    checks++;
                    if (cyc - last_acc != 3) begin errors++; $display("FAIL arb_interval got=%0d exp=3", cyc - last_acc); end
                end
                push_exp(gexp, rq[gexp]);
                last_acc = cyc;
                gexp = ~gexp;
                n_acc++;
                acc_now = 1;
            end
            if (rsp_valid) begin
                o = '{id: rsp_id, we: rsp_we, a: rsp_a, b: rsp_b};
                e = (q.size() > 0) ? q.pop_front() : '0;
                checks++;
                if (o !== e) begin errors++; $display("FAIL arb_rsp n=%0d got=%h exp=%h", n_rsp, o, e); end
                n_rsp++;
            end
            if (n_acc >= 4 && !acc_now) req_valid = 2'b00;
            @(negedge clk);
        end
        req_valid = 2'b00;
        checks++; if (n_rsp != 4) begin errors++; $display("FAIL arb_count got=%0d exp=4", n_rsp); end
    endtask

    task automatic test_hold();
        bit ok; int acc; int lat; exp_t o; exp_t e; exp_t h;
        rsp_ready = 1'b0;
        xact(1'b0, '{we: 1'b0, addr_a: 8'd3, addr_b: 8'd2, wdata: 32'd0}, ok, acc, lat, o, e);
        checks++; if (!ok || o !== e) begin errors++; $display("FAIL hold_rsp got=%h exp=%h", o, e); end
        req_we[1] = 1'b0; req_addr_a[1] = 8'd2; req_addr_b[1] = 8'd2; req_valid[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            h = '{id: rsp_id, we: rsp_we, a: rsp_a, b: rsp_b};
            checks++;
            if (rsp_valid !== 1'b1 || h !== e || req_ready !== 2'b00) begin
                errors++; $display("FAIL hold_stable cyc=%0d got v=%b rsp=%h rdy=%b exp v=1 rsp=%h rdy=00",
                                   i, rsp_valid, h, req_ready, e);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 2'b10) begin
            errors++; $display("FAIL hold_release got v=%b rdy=%b exp v=0 rdy=10", rsp_valid, req_ready);
        end
        req_valid[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_exec();
        bit ok; int acc; int lat; exp_t o; exp_t e;
        xact(1'b0, '{we: 1'b1, addr_a: 8'd4, addr_b: 8'd0, wdata: 32'd55}, ok, acc, lat, o, e);
        checks++; if (!ok || o !== e) begin errors++; $display("FAIL wr55_rsp got=%h exp=%h", o, e); end
        drive_req(1'b0, '{we: 1'b1, addr_a: 8'd4, addr_b: 8'd0, wdata: 32'd999});
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (req_ready[0]) ok = 1;
            else @(negedge clk);
        end
        checks++; if (!ok) begin errors++; $display("FAIL wr999_accept got req_ready=%b exp handshake", req_ready); end
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        checks++;
        if (rf_ld !== 1'b1 || rf_sel_a !== 8'd4 || rf_in !== 32'd999) begin
            errors++; $display("FAIL exec_write got ld=%b sa=%0d in=%0d exp ld=1 sa=4 in=999", rf_ld, rf_sel_a, rf_in);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (rf_ld !== 1'b0) begin errors++; $display("FAIL rst_drop_ld got=%b exp=0", rf_ld); end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_a !== '0 || rsp_b !== '0) begin
            errors++; $display("FAIL rst_exec_outputs got v=%b a=%h b=%h exp 0/0/0", rsp_valid, rsp_a, rsp_b);
        end
        rst = 1'b0;
        last_a = '0;
        last_b = '0;
        q.delete();
        xact(1'b0, '{we: 1'b0, addr_a: 8'd4, addr_b: 8'd4, wdata: 32'd0}, ok, acc, lat, o, e);
        checks++;
        if (!ok || o.a !== 32'd55 || o.b !== 32'd55 || o !== e) begin
            errors++; $display("FAIL rd4_after_abort got a=%0d b=%0d exp a=55 b=55", o.a, o.b);
        end
        @(negedge clk);
    endtask

    initial begin
        req_valid  = '0;
        req_we     = '0;
        req_addr_a = '0;
        req_addr_b = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b1;
        for (int i = 0; i < 256; i++) sh[i] = '0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_arbitration();
        test_hold();
        test_reset_exec();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_arbiter.md
# reg_file_arbiter

Shares the single `register_file` instance between two requesters, for example the CPU control unit on port 0 and a debug/loader path on port 1. The block accepts one read or write request at a time through a valid/ready handshake, with round-robin arbitration. It sequences the file's `ld`/`oe_a`/`oe_b`/`sel_a`/`sel_b`/`in` controls and returns captured read data through a valid/ready response channel. Every access is serialized because a write uses `sel_a` and would otherwise collide with a read on port A.

## Interface
- `DATA_WIDTH`, 32, register width
- `SEL_WIDTH`, 8, register select width
- `clk`  in  1  clock; single clock domain
- `rst`  in  1  reset; asynchronous, active-high
- `req_valid`  in  [1:0]  request valid per requester
- `req_ready`  out  [1:0]  request accepted this cycle
- `req_we[i]`  in  1 each  1 = write, 0 = read
- `req_addr_a[i]`, `req_addr_b[i]`  in  SEL_WIDTH each  register selects (write uses addr_a)
- `req_wdata[i]`  in  DATA_WIDTH each  write data
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response consumed
- `rsp_id`  out  1  requester that owns the response
- `rsp_we`  out  1  echo of the accepted op type
- `rsp_a`, `rsp_b`  out  DATA_WIDTH  read data
- `rf_ld`, `rf_oe_a`, `rf_oe_b`  out  1  register file controls
- `rf_sel_a`, `rf_sel_b`  out  SEL_WIDTH  register file selects
- `rf_in`  out  DATA_WIDTH  register file write data
- `rf_a`, `rf_b`  in  DATA_WIDTH  register file read buses

## Operation
- States: IDLE, EXEC, RESP.
- **IDLE**
  - Grant goes to the requester whose `req_valid` is high. If both are high, the one not named by `last_grant` wins.
  - `req_ready[grant]` is combinational and is high only in IDLE.
  - On valid&&ready, latch we, addr_a, addr_b, wdata and id; update `last_grant` to id; go to EXEC.
- **EXEC** (exactly one cycle); controls are decoded from state and the latched op:
  - Write: `rf_ld`=1, `rf_sel_a`=addr_a, `rf_in`=wdata, both oe=0. The register file loads on the edge that ends EXEC.
  - Read: `rf_oe_a`=`rf_oe_b`=1, `rf_ld`=0, selects = latched addrs. `rf_a` and `rf_b` are captured into `rsp_a`/`rsp_b` on the edge that ends EXEC.
  - Go to RESP.
- **RESP**
  - `rsp_valid`=1 with `rsp_id` and `rsp_we`.
  - On a write, `rsp_a`/`rsp_b` keep their previous values.
  - Hold until `rsp_ready`, then go to IDLE.
- Outside EXEC, all `rf_*` controls are 0 and the selects/`rf_in` are 0. The tri buses are therefore never driven by the file when nobody is sampling them.
- A requester must hold `req_valid` and its payload stable until ready. The block does not check this.

## Timing
- Reset values: state=IDLE, `last_grant`=1 (port 0 wins the first tie), `req_ready`=0 while `rst`=1, `rsp_valid`=0, `rsp_id`=0, `rsp_we`=0, `rsp_a`=`rsp_b`=0. Every `rf_*` output is 0.
- Latency: accept at edge t → EXEC during cycle t+1 → `rsp_valid` high from edge t+2. Minimum 3 cycles per access with `rsp_ready` tied high; back-to-back requests are accepted every 3 cycles.
- Only one outstanding request; no request is accepted while in EXEC or RESP.
- A single valid requester is granted regardless of `last_grant`.
- Reset asserted during EXEC drops `rf_ld` immediately. No write occurs if `rst` is high at the ending edge.
- Reset asserted in RESP discards the pending response.
- `rsp_ready` high in the same cycle `rsp_valid` rises completes the response in that cycle.

## Structure
- Package `reg_file_arbiter_pkg`:
  - typedef enum `rfa_state_e` {IDLE, EXEC, RESP}
  - constant `NUM_REQ`=2
  - packed struct `rfa_req_t` {we, addr_a, addr_b, wdata}
- Sub-module `rr_arbiter2`: combinational 2-way round-robin grant from `req_valid` and `last_grant`. The parent owns the `last_grant` flop.

## Test plan
- Port 0 writes reg 2 = 123, then reads addrs (2,2) → RESP with `rsp_id`=0, `rsp_a`=`rsp_b`=123; `rsp_valid` 2 cycles after each accept.
- Port 1 writes reg 3 = 321, port 0 rewrites reg 2 = 567; a read of (2,3) → `rsp_a`=567, `rsp_b`=321.
- Both valid from reset, reads → port 0 granted first and port 1 next; then both valid again → port 0, alternating strictly.
- Hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid` and data stable, `req_ready`=0 throughout; release → IDLE next cycle.
- Assert `rst` during EXEC of a write of 999 to reg 4 whose prior value is 55 → `rf_ld` falls at once; a later read of reg 4 returns 55.
- Check `rf_oe_a`/`rf_oe_b`/`rf_ld` are 0 in every IDLE and RESP cycle, and never both ld and oe in EXEC.
